// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_pkg
//  Description : Shared definitions for the machine-mode CSR unit: CSR
//                addresses, mstatus/mie/mip bit positions, interrupt cause
//                codes, the func3 operation encoding and small helpers for
//                the read-modify-write operations and mtvec legalisation.
//                The counter CSR addresses are used only when the
//                CSR_COUNTERS_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Bit positions inside mstatus / mie / mip
    localparam int MIE  = 3;
    localparam int MPIE = 7;
    localparam int MTIE = 7;
    localparam int MEIE = 11;
    localparam int MTIP = 7;
    localparam int MEIP = 11;

    // Interrupt cause codes (mcause[3:0], interrupt bit set separately)
    localparam logic [3:0] CAUSE_M_TIMER = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT   = 4'd11;

    // func3 encoding of the Zicsr instructions
    typedef enum logic [2:0] {
        CSR_OP_NONE  = 3'b000,
        CSRRW        = 3'b001,
        CSRRS        = 3'b010,
        CSRRC        = 3'b011,
        CSR_OP_NONEI = 3'b100,
        CSRRWI       = 3'b101,
        CSRRSI       = 3'b110,
        CSRRCI       = 3'b111
    } csr_op_e;

    // Read-modify-write result for func3[1:0]; op 00 leaves the value alone.
    function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] src);
        logic [31:0] res;
        case (op)
            2'b01:   res = src;
            2'b10:   res = old_val | src;
            2'b11:   res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

    // mtvec only supports direct (0) and vectored (1); reserved modes fall
    // back to direct.
    function automatic logic [31:0] mtvec_legalize(input logic [31:0] v);
        return {v[31:2], (v[1] ? 2'b00 : v[1:0])};
    endfunction

endpackage : csr_pkg
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter64
//  Description : 64-bit performance counter with independently writable
//                32-bit halves. A write to either half takes precedence over
//                the increment in that cycle; the increment carries from the
//                low half into the high half in the same cycle.
//                Instantiated by csr_unit only when CSR_COUNTERS_EN is set.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                inc_i         - count enable
//                wr_lo_i/wr_hi_i - replace low/high half with wdata_i
//                wdata_i       - write data
//                value_o       - current 64-bit count
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i;
            if (wr_hi_i) cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;

endmodule : csr_counter64
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_unit
//  Description : Machine-mode CSR file and trap/return sequencer for stage 3
//                of the RV32I pipeline. Provides combinational read data for
//                the writeback mux, commits CSR writes, takes interrupts and
//                executes mret, producing a one-cycle redirect strobe/target.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                instr_valid, pc       - stage-3 instruction qualifier and PC
//                csr_addr, func3       - CSR address and operation
//                rs1_data, zimm        - register / immediate write source
//                csr_reg_rd/_wr, is_mret - controller decode
//                timer_irq, ext_irq    - level interrupt requests
//                csr_rdata             - read data (0 when not reading)
//                epc_taken, epc        - redirect strobe and target
//  Options     : CSR_COUNTERS_EN adds mcycle/minstret (0xB00/0xB80,
//                0xB02/0xB82). Without it those addresses read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [11:0]     csr_addr,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      zimm,
    input  logic            csr_reg_rd,
    input  logic            csr_reg_wr,
    input  logic            is_mret,
    input  logic            timer_irq,
    input  logic            ext_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            epc_taken,
    output logic [XLEN-1:0] epc
);

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q,     mie_mtie_d;
    logic        mie_meie_q,     mie_meie_d;
    logic [31:0] mtvec_q,        mtvec_d;
    logic [31:2] mepc_q,         mepc_d;
    logic [31:0] mcause_q,       mcause_d;
    logic        mip_mtip_q;
    logic        mip_meip_q;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [31:0] csr_old;
    logic [31:0] csr_src;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_op;
    logic        csr_wr_en;
    logic        irq_pending;
    logic        trap;
    logic        mret_fire;
    logic [3:0]  cause_code;
    logic [31:0] mtvec_base;
    logic        unused_pc_lsbs;

    // mepc is word aligned, so the low PC bits are never stored.
    assign unused_pc_lsbs = ^pc[1:0];

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_val;
    logic [63:0] minstret_val;
`endif

    // Current value of the addressed CSR, independent of csr_reg_rd. It is
    // both the read data and the "old" operand of RS/RC, which gives
    // read-before-write for free.
    always_comb begin
        csr_old = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_old[MIE]  = mstatus_mie_q;
                csr_old[MPIE] = mstatus_mpie_q;
            end
            CSR_MIE: begin
                csr_old[MTIE] = mie_mtie_q;
                csr_old[MEIE] = mie_meie_q;
            end
            CSR_MTVEC:  csr_old = mtvec_q;
            CSR_MEPC:   csr_old = {mepc_q, 2'b00};
            CSR_MCAUSE: csr_old = mcause_q;
            CSR_MIP: begin
                csr_old[MTIP] = mip_mtip_q;
                csr_old[MEIP] = mip_meip_q;
            end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    csr_old = mcycle_val[31:0];
            CSR_MCYCLEH:   csr_old = mcycle_val[63:32];
            CSR_MINSTRET:  csr_old = minstret_val[31:0];
            CSR_MINSTRETH: csr_old = minstret_val[63:32];
`endif
            default: csr_old = '0;
        endcase
    end

    assign csr_rdata = csr_reg_rd ? csr_old : '0;

    assign csr_src   = func3[2] ? {27'b0, zimm} : rs1_data;
    assign csr_op    = func3[1:0];
    assign csr_wdata = csr_apply(csr_op, csr_old, csr_src);

    // Interrupt evaluation. Reset is folded in so that nothing redirects
    // while rst is asserted, even if an interrupt is already pending.
    assign irq_pending = mstatus_mie_q &
                         ((mie_meie_q & mip_meip_q) | (mie_mtie_q & mip_mtip_q));
    assign mret_fire   = !rst && is_mret && instr_valid;
    assign trap        = !rst && irq_pending && instr_valid && !is_mret;
    assign cause_code  = (mie_meie_q && mip_meip_q) ? CAUSE_M_EXT : CAUSE_M_TIMER;

    // A trapped instruction is squashed, and RS/RC with a zero source must
    // not write (no side effect on registers with write behaviour).
    assign csr_wr_en = csr_reg_wr && instr_valid && !trap && (csr_op != 2'b00) &&
                       ((csr_op == 2'b01) || (csr_src != 32'd0));

    assign mtvec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        epc_taken = trap || mret_fire;
        epc       = '0;
        if (mret_fire) begin
            epc = {mepc_q, 2'b00};
        end else if (trap) begin
            epc = (mtvec_q[1:0] == 2'b01) ? (mtvec_base + {26'b0, cause_code, 2'b00})
                                          : mtvec_base;
        end
    end

    // Next-state: CSR writes first, then trap entry / mret which own mstatus.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;

        if (csr_wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata[MIE];
                    mstatus_mpie_d = csr_wdata[MPIE];
                end
                CSR_MIE: begin
                    mie_mtie_d = csr_wdata[MTIE];
                    mie_meie_d = csr_wdata[MEIE];
                end
                CSR_MTVEC:  mtvec_d  = mtvec_legalize(csr_wdata);
                CSR_MEPC:   mepc_d   = csr_wdata[31:2];
                CSR_MCAUSE: mcause_d = csr_wdata;
                default: ;
            endcase
        end

        if (trap) begin
            mepc_d         = pc[31:2];
            mcause_d       = {1'b1, 27'b0, cause_code};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_fire) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= mtvec_legalize(RESET_MTVEC);
            mepc_q         <= '0;
            mcause_q       <= '0;
            mip_mtip_q     <= 1'b0;
            mip_meip_q     <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            // Single-flop registration of the level interrupt lines.
            mip_mtip_q     <= timer_irq;
            mip_meip_q     <= ext_irq;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .wr_lo_i (csr_wr_en && (csr_addr == CSR_MCYCLE)),
        .wr_hi_i (csr_wr_en && (csr_addr == CSR_MCYCLEH)),
        .wdata_i (csr_wdata),
        .value_o (mcycle_val)
    );

    // An instruction retires when it is valid and not squashed by a trap.
    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (instr_valid && !trap),
        .wr_lo_i (csr_wr_en && (csr_addr == CSR_MINSTRET)),
        .wr_hi_i (csr_wr_en && (csr_addr == CSR_MINSTRETH)),
        .wdata_i (csr_wdata),
        .value_o (minstret_val)
    );
`endif

endmodule : csr_unit
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_unit
//  Description : Self-checking bench for csr_unit. Each scenario task builds
//                a table of per-cycle instructions; the expected read data and
//                redirect are pushed to a scoreboard when the instruction is
//                driven and popped/compared at the following falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] pc;
    logic [11:0] csr_addr;
    logic [2:0]  func3;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        csr_reg_rd;
    logic        csr_reg_wr;
    logic        is_mret;
    logic        timer_irq;
    logic        ext_irq;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    csr_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .pc          (pc),
        .csr_addr    (csr_addr),
        .func3       (func3),
        .rs1_data    (rs1_data),
        .zimm        (zimm),
        .csr_reg_rd  (csr_reg_rd),
        .csr_reg_wr  (csr_reg_wr),
        .is_mret     (is_mret),
        .timer_irq   (timer_irq),
        .ext_irq     (ext_irq),
        .csr_rdata   (csr_rdata),
        .epc_taken   (epc_taken),
        .epc         (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] pc;
        logic [11:0] addr;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        rd;
        logic        wr;
        logic        mret;
        logic        tirq;
        logic        eirq;
        logic [31:0] rdata;
        logic        taken;
        logic [31:0] epc;
    } step_t;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        taken;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];

    // Full step description
    function automatic step_t S(logic r, logic v, logic [31:0] p, logic [11:0] a,
                                logic [2:0] f3, logic [31:0] rs1, logic [4:0] z,
                                logic rd, logic wr, logic mret, logic t, logic e,
                                logic [31:0] rdata, logic taken, logic [31:0] ep);
        step_t s;
        s.rst = r; s.v = v; s.pc = p; s.addr = a; s.f3 = f3; s.rs1 = rs1;
        s.zimm = z; s.rd = rd; s.wr = wr; s.mret = mret; s.tirq = t; s.eirq = e;
        s.rdata = rdata; s.taken = taken; s.epc = ep;
        return s;
    endfunction

    // Plain read (CSRRS with rs1=0 decoded as read-only), no redirect expected
    function automatic step_t R(logic v, logic [11:0] a, logic t, logic e,
                                logic [31:0] rdata);
        return S(1'b0, v, 32'h200, a, 3'b010, 32'h0, 5'h0, 1'b1, 1'b0, 1'b0,
                 t, e, rdata, 1'b0, 32'h0);
    endfunction

    // Valid CSR write instruction that also reads, no redirect expected
    function automatic step_t W(logic [11:0] a, logic [2:0] f3, logic [31:0] rs1,
                                logic [4:0] z, logic t, logic e, logic [31:0] rdata);
        return S(1'b0, 1'b1, 32'h200, a, f3, rs1, z, 1'b1, 1'b1, 1'b0,
                 t, e, rdata, 1'b0, 32'h0);
    endfunction

    // Reset cycle: no read, no redirect allowed
    function automatic step_t RST(logic v, logic t, logic e);
        return S(1'b1, v, 32'h40, 12'h300, 3'b001, 32'hFFFF_FFFF, 5'h0, 1'b0,
                 1'b1, 1'b0, t, e, 32'h0, 1'b0, 32'h0);
    endfunction

    // Drives one instruction just after the rising edge and records what the
    // combinational outputs must show for it.
    task automatic issue(input step_t s, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = s.rst;
        instr_valid = s.v;
        pc          = s.pc;
        csr_addr    = s.addr;
        func3       = s.f3;
        rs1_data    = s.rs1;
        zimm        = s.zimm;
        csr_reg_rd  = s.rd;
        csr_reg_wr  = s.wr;
        is_mret     = s.mret;
        timer_irq   = s.tirq;
        ext_irq     = s.eirq;
        e.name  = nm;
        e.rdata = s.rdata;
        e.taken = s.taken;
        e.epc   = s.epc;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(RST(1'b1, 1'b1, 1'b1));
        tbl.push_back(RST(1'b1, 1'b1, 1'b1));
        tbl.push_back(R(1'b0, 12'h300, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'h305, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'h344, 1'b0, 1'b0, 32'h0));
        foreach (tbl[i]) begin
            issue(tbl[i], $sformatf("reset[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (csr_rdata !== e.rdata || epc_taken !== e.taken ||
                (e.taken && epc !== e.epc)) begin
                errors++;
                $display("FAIL %s: got rdata=%h taken=%b epc=%h, want rdata=%h taken=%b epc=%h",
                         e.name, csr_rdata, epc_taken, epc, e.rdata, e.taken, e.epc);
            end
        end
    endtask

    task automatic test_mtvec();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(W(12'h305, 3'b001, 32'h0000_1003, 5'h0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(W(12'h305, 3'b010, 32'h0, 5'h0, 1'b0, 1'b0, 32'h0000_1000));
        tbl.push_back(R(1'b1, 12'h305, 1'b0, 1'b0, 32'h0000_1000));
        // Write with instr_valid low must not commit
        tbl.push_back(S(1'b0, 1'b0, 32'h200, 12'h305, 3'b001, 32'h2000, 5'h0, 1'b1,
                        1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 32'h0));
        tbl.push_back(R(1'b1, 12'h305, 1'b0, 1'b0, 32'h0000_1000));
        foreach (tbl[i]) begin
            issue(tbl[i], $sformatf("mtvec[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (csr_rdata !== e.rdata || epc_taken !== e.taken ||
                (e.taken && epc !== e.epc)) begin
                errors++;
                $display("FAIL %s: got rdata=%h taken=%b epc=%h, want rdata=%h taken=%b epc=%h",
                         e.name, csr_rdata, epc_taken, epc, e.rdata, e.taken, e.epc);
            end
        end
    endtask

    task automatic test_trap_entry();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(W(12'h304, 3'b001, 32'h800, 5'h0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(W(12'h300, 3'b001, 32'h8, 5'h0, 1'b0, 1'b1, 32'h0));
        // CSRRW to mtvec at pc=0x40 is squashed by the external interrupt
        tbl.push_back(S(1'b0, 1'b1, 32'h40, 12'h305, 3'b001, 32'h5000, 5'h0, 1'b1,
                        1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_1000));
        tbl.push_back(R(1'b1, 12'h341, 1'b0, 1'b1, 32'h0000_0040));
        tbl.push_back(R(1'b1, 12'h342, 1'b0, 1'b1, 32'h8000_000B));
        tbl.push_back(R(1'b1, 12'h300, 1'b0, 1'b1, 32'h0000_0080));
        tbl.push_back(R(1'b1, 12'h305, 1'b0, 1'b1, 32'h0000_1000));
        foreach (tbl[i]) begin
            issue(tbl[i], $sformatf("trap[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (csr_rdata !== e.rdata || epc_taken !== e.taken ||
                (e.taken && epc !== e.epc)) begin
                errors++;
                $display("FAIL %s: got rdata=%h taken=%b epc=%h, want rdata=%h taken=%b epc=%h",
                         e.name, csr_rdata, epc_taken, epc, e.rdata, e.taken, e.epc);
            end
        end
    endtask

    task automatic test_mret();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(S(1'b0, 1'b1, 32'h1000, 12'h0, 3'b000, 32'h0, 5'h0, 1'b0, 1'b0,
                        1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0000_0040));
        tbl.push_back(R(1'b0, 12'h300, 1'b0, 1'b1, 32'h0000_0088));
        // Interrupt pending and enabled, but mret has priority
        tbl.push_back(S(1'b0, 1'b1, 32'h1004, 12'h0, 3'b000, 32'h0, 5'h0, 1'b0, 1'b0,
                        1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h0000_0040));
        tbl.push_back(R(1'b0, 12'h342, 1'b0, 1'b0, 32'h8000_000B));
        tbl.push_back(R(1'b0, 12'h341, 1'b0, 1'b0, 32'h0000_0040));
        foreach (tbl[i]) begin
            issue(tbl[i], $sformatf("mret[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (csr_rdata !== e.rdata || epc_taken !== e.taken ||
                (e.taken && epc !== e.epc)) begin
                errors++;
                $display("FAIL %s: got rdata=%h taken=%b epc=%h, want rdata=%h taken=%b epc=%h",
                         e.name, csr_rdata, epc_taken, epc, e.rdata, e.taken, e.epc);
            end
        end
    endtask

    task automatic test_vectored();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(W(12'h305, 3'b001, 32'h101, 5'h0, 1'b0, 1'b0, 32'h0000_1000));
        tbl.push_back(W(12'h304, 3'b001, 32'h880, 5'h0, 1'b1, 1'b1, 32'h0000_0800));
        // Both pending: external wins, 0x100 + 4*11
        tbl.push_back(S(1'b0, 1'b1, 32'h80, 12'h304, 3'b010, 32'h0, 5'h0, 1'b1, 1'b0,
                        1'b0, 1'b1, 1'b1, 32'h0000_0880, 1'b1, 32'h0000_012C));
        tbl.push_back(R(1'b1, 12'h342, 1'b1, 1'b0, 32'h8000_000B));
        tbl.push_back(S(1'b0, 1'b1, 32'h1000, 12'h0, 3'b000, 32'h0, 5'h0, 1'b0, 1'b0,
                        1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0080));
        // Timer only: 0x100 + 4*7
        tbl.push_back(S(1'b0, 1'b1, 32'h84, 12'h344, 3'b010, 32'h0, 5'h0, 1'b1, 1'b0,
                        1'b0, 1'b1, 1'b0, 32'h0000_0080, 1'b1, 32'h0000_011C));
        tbl.push_back(R(1'b1, 12'h342, 1'b0, 1'b0, 32'h8000_0007));
        tbl.push_back(R(1'b1, 12'h341, 1'b0, 1'b0, 32'h0000_0084));
        tbl.push_back(W(12'h305, 3'b001, 32'h202, 5'h0, 1'b0, 1'b0, 32'h0000_0101));
        tbl.push_back(R(1'b1, 12'h305, 1'b0, 1'b0, 32'h0000_0200));
        foreach (tbl[i]) begin
            issue(tbl[i], $sformatf("vectored[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (csr_rdata !== e.rdata || epc_taken !== e.taken ||
                (e.taken && epc !== e.epc)) begin
                errors++;
                $display("FAIL %s: got rdata=%h taken=%b epc=%h, want rdata=%h taken=%b epc=%h",
                         e.name, csr_rdata, epc_taken, epc, e.rdata, e.taken, e.epc);
            end
        end
    endtask

    task automatic test_rc_ignored();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(W(12'h300, 3'b110, 32'h0, 5'd8, 1'b0, 1'b0, 32'h0000_0080));
        tbl.push_back(W(12'h300, 3'b111, 32'h0, 5'd8, 1'b0, 1'b0, 32'h0000_0088));
        tbl.push_back(R(1'b1, 12'h300, 1'b0, 1'b0, 32'h0000_0080));
        tbl.push_back(W(12'h344, 3'b010, 32'hFFFF_FFFF, 5'h0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(W(12'h7C0, 3'b010, 32'hFFFF_FFFF, 5'h0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b1, 12'h7C0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(W(12'h300, 3'b001, 32'hFFFF_FFFF, 5'h0, 1'b0, 1'b0, 32'h0000_0080));
        tbl.push_back(W(12'h341, 3'b001, 32'h0000_1237, 5'h0, 1'b0, 1'b0, 32'h0000_0084));
        tbl.push_back(R(1'b1, 12'h341, 1'b0, 1'b0, 32'h0000_1234));
        tbl.push_back(R(1'b1, 12'h300, 1'b0, 1'b0, 32'h0000_0088));
        tbl.push_back(W(12'h300, 3'b111, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0000_0088));
        tbl.push_back(R(1'b1, 12'h300, 1'b0, 1'b0, 32'h0000_0088));
        // mip follows timer_irq one cycle late; bubbles never trap
        tbl.push_back(R(1'b0, 12'h344, 1'b1, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'h344, 1'b1, 1'b0, 32'h0000_0080));
        tbl.push_back(R(1'b0, 12'h344, 1'b0, 1'b0, 32'h0000_0080));
        tbl.push_back(R(1'b0, 12'h344, 1'b0, 1'b0, 32'h0));
        foreach (tbl[i]) begin
            issue(tbl[i], $sformatf("rc_ignored[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (csr_rdata !== e.rdata || epc_taken !== e.taken ||
                (e.taken && epc !== e.epc)) begin
                errors++;
                $display("FAIL %s: got rdata=%h taken=%b epc=%h, want rdata=%h taken=%b epc=%h",
                         e.name, csr_rdata, epc_taken, epc, e.rdata, e.taken, e.epc);
            end
        end
    endtask

    task automatic test_reset_mid_trap();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(R(1'b0, 12'h300, 1'b0, 1'b1, 32'h0000_0088));
        tbl.push_back(RST(1'b1, 1'b0, 1'b1));
        tbl.push_back(R(1'b0, 12'h300, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'h305, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'h304, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'h341, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'h342, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'h344, 1'b0, 1'b0, 32'h0));
        foreach (tbl[i]) begin
            issue(tbl[i], $sformatf("reset_mid[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (csr_rdata !== e.rdata || epc_taken !== e.taken ||
                (e.taken && epc !== e.epc)) begin
                errors++;
                $display("FAIL %s: got rdata=%h taken=%b epc=%h, want rdata=%h taken=%b epc=%h",
                         e.name, csr_rdata, epc_taken, epc, e.rdata, e.taken, e.epc);
            end
        end
    endtask

    task automatic test_counters();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(RST(1'b0, 1'b0, 1'b0));
`ifdef CSR_COUNTERS_EN
        tbl.push_back(W(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'h0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'hB00, 1'b0, 1'b0, 32'hFFFF_FFFF));
        tbl.push_back(R(1'b0, 12'hB80, 1'b0, 1'b0, 32'h0000_0001));
        tbl.push_back(R(1'b0, 12'hB00, 1'b0, 1'b0, 32'h0000_0001));
        tbl.push_back(R(1'b0, 12'hB02, 1'b0, 1'b0, 32'h0000_0001));
        tbl.push_back(R(1'b0, 12'hB82, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b1, 12'hB02, 1'b0, 1'b0, 32'h0000_0001));
        tbl.push_back(R(1'b0, 12'hB02, 1'b0, 1'b0, 32'h0000_0002));
        tbl.push_back(W(12'hB02, 3'b001, 32'h10, 5'h0, 1'b0, 1'b0, 32'h0000_0002));
        tbl.push_back(R(1'b0, 12'hB02, 1'b0, 1'b0, 32'h0000_0010));
`else
        tbl.push_back(W(12'hB00, 3'b001, 32'hFFFF_FFFF, 5'h0, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'hB00, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'hB80, 1'b0, 1'b0, 32'h0));
        tbl.push_back(R(1'b0, 12'hB02, 1'b0, 1'b0, 32'h0));
`endif
        foreach (tbl[i]) begin
            issue(tbl[i], $sformatf("counters[%0d]", i));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (csr_rdata !== e.rdata || epc_taken !== e.taken ||
                (e.taken && epc !== e.epc)) begin
                errors++;
                $display("FAIL %s: got rdata=%h taken=%b epc=%h, want rdata=%h taken=%b epc=%h",
                         e.name, csr_rdata, epc_taken, epc, e.rdata, e.taken, e.epc);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        pc          = '0;
        csr_addr    = '0;
        func3       = '0;
        rs1_data    = '0;
        zimm        = '0;
        csr_reg_rd  = 1'b0;
        csr_reg_wr  = 1'b0;
        is_mret     = 1'b0;
        timer_irq   = 1'b0;
        ext_irq     = 1'b0;

        test_reset();
        test_mtvec();
        test_trap_entry();
        test_mret();
        test_vectored();
        test_rc_ignored();
        test_reset_mid_trap();
        test_counters();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_csr_unit
`default_nettype wire
